display_frame_sequencer: RTL and testbench
==========================================

Name: display_frame_sequencer

Overview:
- Sequences one full frame of pixels from the frame-buffer read port into the single-pixel display driver (input_rgb/input_valid/busy interface).
- Generates linear read addresses and raster coordinates, and obeys the driver's busy handshake.
- Counts completed frames. Optionally substitutes a constant test-pattern colour for memory data.
- Sits between the frame buffer / image processor output memory and the display driver.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- MEM_LAT, 2, fixed read latency in cycles from mem_rd_en to mem_rd_data valid (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin one frame
- abort  in  1  single-cycle pulse; terminate frame immediately
- pattern_en  in  1  1 = send pattern_rgb instead of memory data; sampled at start
- pattern_rgb  in  24  test colour {R,G,B}
- mem_rd_en  out  1  read strobe, one cycle per pixel
- mem_addr  out  ADDR_W  linear read address
- mem_rd_data  in  24  read data, valid exactly MEM_LAT cycles after mem_rd_en
- drv_rgb  out  24  pixel to driver input_rgb
- drv_valid  out  1  to driver input_valid, one-cycle pulse
- drv_busy  in  1  from driver busy
- frame_active  out  1  high from start acceptance until DONE/abort
- frame_done  out  1  one-cycle pulse after last pixel handed off
- pixel_x  out  clog2(H_RES)  column of the pixel currently being issued
- pixel_y  out  clog2(V_RES)  row of the pixel currently being issued
- frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: mem_rd_en, mem_addr, drv_rgb, drv_valid, frame_active, frame_done, pixel_x, pixel_y, frame_count. Latched pattern mode cleared.
- All outputs are registered.
- States: IDLE, FETCH, WAIT_DATA, ISSUE, ARM, WAIT_DRV, DONE.
- IDLE: on start (and no abort) -> clear x, y, addr; latch pattern_en; frame_active<=1; next state FETCH.
- FETCH: if pattern mode, skip memory and go directly to ISSUE. Else mem_rd_en<=1 for one cycle with mem_addr; latency counter<=MEM_LAT; -> WAIT_DATA.
- WAIT_DATA: decrement counter; when it reaches the data-valid cycle, capture mem_rd_data -> ISSUE.
- ISSUE: wait until drv_busy==0, then drv_rgb<=pixel (captured data or pattern_rgb), drv_valid<=1 for exactly one cycle -> ARM.
- ARM: one-cycle guard, because the driver raises busy one cycle after accepting valid -> WAIT_DRV.
- WAIT_DRV: wait for drv_busy==0. Then:
  - Last pixel (x==H_RES-1 and y==V_RES-1) -> DONE.
  - Otherwise advance addr+1; x+1, and when x==H_RES-1, x<=0 and y+1 -> FETCH.
- DONE: frame_done<=1 for one cycle; frame_count+1 (16-bit wrap); frame_active<=0 -> IDLE.
- At most one pixel is outstanding to the driver at any time. drv_valid is never asserted while drv_busy=1.
- Throughput, pattern mode: min 4 cycles/pixel plus driver occupancy. Memory mode adds 1+MEM_LAT cycles.
- abort (any state except IDLE): next cycle state=IDLE; drv_valid and mem_rd_en forced 0; frame_active<=0; no frame_done; frame_count unchanged; in-flight read data discarded. x, y, addr hold their values until the next start clears them.
- abort in IDLE: no effect. Same-cycle start+abort: abort wins, frame not started.
- start while frame_active: ignored. pattern_en changes mid-frame: ignored.
- Reset mid-frame: immediate return to reset values; driver sees drv_valid=0.
- mem_addr stays at the last pixel address after DONE; it is not wrapped.

Decomposition:
- Shared package display_pkg:
  - state encoding (localparams, 3 bits)
  - RGB width constant PIX_W=24
  - default H_RES/V_RES
  - frame counter width FCNT_W=16
- One sub-module is natural: raster_counter (x/y/addr counters with advance, clear and last-pixel flag). The FSM and handshake stay in the top module.

Test Plan:
- H_RES=4, V_RES=2, MEM_LAT=2, memory model returns addr*0x010101, driver model from the team's display driver. start -> 8 drv_valid pulses with drv_rgb 0x000000..0x070707 in order; pixel_x/pixel_y follow (0,0)..(3,1); frame_done pulses once; frame_count=1.
- pattern_en=1, pattern_rgb=0xFF0000, start -> 8 pulses of 0xFF0000; mem_rd_en never asserted; frame_count increments.
- Driver held busy 10 extra cycles per pixel -> drv_valid never coincides with drv_busy=1; exactly 8 pixels delivered; ordering preserved.
- abort after the 3rd drv_valid -> frame_active falls the next cycle; no further drv_valid or mem_rd_en; frame_done never pulses; frame_count unchanged. A new start then delivers all 8 pixels from address 0.
- start and abort in the same cycle, and start while active -> no frame begins or restarts; the in-progress frame completes normally with exactly 8 pixels.
- Preload frame_count to 65535 by running frames (or force) -> the next frame_done sets it to 0. rst_n asserted mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/display_frame_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the display frame sequencer.
package display_pkg;

   localparam int PIX_W     = 24;
   localparam int FCNT_W    = 16;
   localparam int DEF_H_RES = 640;
   localparam int DEF_V_RES = 480;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_WAIT_DATA = 3'd2,
      ST_ISSUE     = 3'd3,
      ST_ARM       = 3'd4,
      ST_WAIT_DRV  = 3'd5,
      ST_DONE      = 3'd6
   } seq_state_e;

   // Completed-frame counter step; wraps naturally at the counter width.
   function automatic logic [FCNT_W-1:0] fcnt_next(input logic [FCNT_W-1:0] cnt);
      return cnt + FCNT_W'(1);
   endfunction

endpackage

// File: rtl/display_frame_sequencer_if.sv
// Frame-buffer read port and pixel-driver handshake, as seen by the sequencer.
interface display_frame_sequencer_if #(
   parameter int ADDR_W = 19
);
   import display_pkg::*;

   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_rd_data;
   logic [PIX_W-1:0]  drv_rgb;
   logic              drv_valid;
   logic              drv_busy;

   modport master (
      output mem_rd_en, mem_addr, drv_rgb, drv_valid,
      input  mem_rd_data, drv_busy
   );

   modport slave (
      input  mem_rd_en, mem_addr, drv_rgb, drv_valid,
      output mem_rd_data, drv_busy
   );

endinterface

// File: rtl/display_frame_sequencer_raster_counter.sv
// Row-major raster position and linear frame-buffer address for one frame.
module raster_counter #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19,
   parameter int XW     = 10,
   parameter int YW     = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              adv_i,
   output logic [XW-1:0]     x_o,
   output logic [YW-1:0]     y_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [ADDR_W-1:0] addr_q;

   // Position register: cleared at frame start, stepped one pixel per advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else if (clr_i) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else if (adv_i) begin
         addr_q <= addr_q + ADDR_W'(1);
         if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
         end else begin
            x_q <= x_q + XW'(1);
         end
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign addr_o = addr_q;
   assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/display_frame_sequencer.sv
// Streams one frame from the frame buffer (or a constant test colour) into the
// single-pixel display driver, one outstanding pixel at a time.
module display_frame_sequencer
   import display_pkg::*;
#(
   parameter int  H_RES   = DEF_H_RES,
   parameter int  V_RES   = DEF_V_RES,
   parameter int  ADDR_W  = 19,
   parameter int  MEM_LAT = 2,
   localparam int XW      = (H_RES > 1) ? $clog2(H_RES) : 1,
   localparam int YW      = (V_RES > 1) ? $clog2(V_RES) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      pattern_en,
   input  logic [PIX_W-1:0]          pattern_rgb,
   display_frame_sequencer_if.master bus,
   output logic                      frame_active,
   output logic                      frame_done,
   output logic [XW-1:0]             pixel_x,
   output logic [YW-1:0]             pixel_y,
   output logic [FCNT_W-1:0]         frame_count
);

   localparam int LW = $clog2(MEM_LAT + 1);

   seq_state_e        state_q;
   logic [LW-1:0]     lat_q;
   logic [PIX_W-1:0]  data_q;
   logic              pat_q;
   logic              rd_en_q;
   logic [PIX_W-1:0]  rgb_q;
   logic              valid_q;
   logic              active_q;
   logic              done_q;
   logic [FCNT_W-1:0] fcnt_q;

   logic              cnt_clr_s;
   logic              cnt_adv_s;
   logic              last_s;
   logic [ADDR_W-1:0] addr_s;

   // Raster counter controls; abort freezes position until the next start.
   always_comb begin
      cnt_clr_s = 1'b0;
      cnt_adv_s = 1'b0;
      if (abort) begin
         cnt_clr_s = 1'b0;
         cnt_adv_s = 1'b0;
      end else if (state_q == ST_IDLE) begin
         cnt_clr_s = start;
      end else if (state_q == ST_WAIT_DRV) begin
         cnt_adv_s = !bus.drv_busy && !last_s;
      end else begin
         cnt_adv_s = 1'b0;
      end
   end

   raster_counter #(
      .H_RES  (H_RES),
      .V_RES  (V_RES),
      .ADDR_W (ADDR_W),
      .XW     (XW),
      .YW     (YW)
   ) u_raster (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr_s),
      .adv_i  (cnt_adv_s),
      .x_o    (pixel_x),
      .y_o    (pixel_y),
      .addr_o (addr_s),
      .last_o (last_s)
   );

   // Frame sequencing FSM with all handshake outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         lat_q    <= '0;
         data_q   <= '0;
         pat_q    <= 1'b0;
         rd_en_q  <= 1'b0;
         rgb_q    <= '0;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         fcnt_q   <= '0;
      end else if (abort && (state_q != ST_IDLE)) begin
         state_q  <= ST_IDLE;
         rd_en_q  <= 1'b0;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  pat_q    <= pattern_en;
                  active_q <= 1'b1;
                  state_q  <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (pat_q) begin
                  state_q <= ST_ISSUE;
               end else begin
                  rd_en_q <= 1'b1;
                  lat_q   <= LW'(MEM_LAT);
                  state_q <= ST_WAIT_DATA;
               end
            end
            // Count reaches zero on the cycle the read data is on the bus.
            ST_WAIT_DATA: begin
               if (lat_q == '0) begin
                  data_q  <= bus.mem_rd_data;
                  state_q <= ST_ISSUE;
               end else begin
                  lat_q <= lat_q - LW'(1);
               end
            end
            ST_ISSUE: begin
               if (!bus.drv_busy) begin
                  rgb_q   <= pat_q ? pattern_rgb : data_q;
                  valid_q <= 1'b1;
                  state_q <= ST_ARM;
               end
            end
            // The driver only raises busy a cycle after it sees valid.
            ST_ARM: begin
               state_q <= ST_WAIT_DRV;
            end
            ST_WAIT_DRV: begin
               if (!bus.drv_busy) begin
                  state_q <= last_s ? ST_DONE : ST_FETCH;
               end
            end
            ST_DONE: begin
               done_q   <= 1'b1;
               fcnt_q   <= fcnt_next(fcnt_q);
               active_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               active_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_rd_en = rd_en_q;
   assign bus.mem_addr  = addr_s;
   assign bus.drv_rgb   = rgb_q;
   assign bus.drv_valid = valid_q;
   assign frame_active  = active_q;
   assign frame_done    = done_q;
   assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Randomized bench: frame-level pixel model, memory and busy-driver models.
module tb_display_frame_sequencer;
   import display_pkg::*;

   localparam int H = 4, V = 2, AW = 4, LAT = 2, NPIX = H * V;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, pattern_en;
   logic [23:0] pattern_rgb;
   logic        frame_active, frame_done;
   logic [1:0]  pixel_x;
   logic [0:0]  pixel_y;
   logic [15:0] frame_count;

   always #5 clk = ~clk;

   display_frame_sequencer_if #(.ADDR_W(AW)) bif ();

   display_frame_sequencer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .pattern_en(pattern_en), .pattern_rgb(pattern_rgb), .bus(bif),
      .frame_active(frame_active), .frame_done(frame_done),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_count(frame_count)
   );

   // Frame buffer: word at address a is a*0x010101, valid LAT cycles after the strobe.
   logic [23:0] pipe_d [LAT];
   logic        pipe_v [LAT];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= 24'd0;
         end
      end else begin
         pipe_v[0] <= bif.mem_rd_en;
         pipe_d[0] <= 24'(bif.mem_addr) * 24'h010101;
         for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end
   assign bif.mem_rd_data = pipe_v[LAT-1] ? pipe_d[LAT-1] : 24'hBADBAD;

   // Driver: busy from the cycle after accepting a pixel, for a random occupancy.
   int busy_left;
   int busy_extra;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_left <= 0;
      else if (bif.drv_valid) busy_left <= int'($urandom_range(3, 1)) + busy_extra;
      else if (busy_left > 0) busy_left <= busy_left - 1;
   end
   assign bif.drv_busy = (busy_left != 0);

   typedef struct { logic [23:0] rgb; int x; int y; int addr; } px_t;
   px_t         exp_q[$];
   px_t         cur_px;
   logic [23:0] log_rgb[$];
   int          log_x[$];
   int          log_y[$];
   int          n_vec = 0, n_err = 0, done_cnt = 0;
   bit          live = 1'b0, rd_pending = 1'b0;
   logic [15:0] model_fcnt = 16'd0;
   // Requests from the stimulus; only the compare process updates the model.
   int          frame_seq = 0, frame_seen = 0, abort_seq = 0, abort_seen = 0;
   int          pre_seq = 0, pre_seen = 0, tmo_cnt = 0, tmo_seen = 0, want_done = 0;
   bit          cur_pat;
   logic [23:0] cur_rgb, pre_val;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Compare process: every cycle, DUT outputs against the frame-level model.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ctrl", 32'({bif.mem_rd_en, bif.drv_valid, frame_active, frame_done, pixel_x, pixel_y}), 32'd0);
         chk("rst_addr", 32'(bif.mem_addr), 32'd0);
         chk("rst_rgb", 32'(bif.drv_rgb), 32'd0);
         chk("rst_fcnt", 32'(frame_count), 32'd0);
         exp_q.delete();
         live = 1'b0; rd_pending = 1'b0; model_fcnt = 16'd0;
         frame_seen = frame_seq; abort_seen = abort_seq;
      end else begin
         if (pre_seq != pre_seen) begin pre_seen = pre_seq; model_fcnt = pre_val; end
         if (abort_seq != abort_seen) begin
            abort_seen = abort_seq; exp_q.delete(); live = 1'b0; rd_pending = 1'b0;
         end
         if (frame_seq != frame_seen) begin
            frame_seen = frame_seq;
            exp_q.delete(); log_rgb.delete(); log_x.delete(); log_y.delete();
            for (int i = 0; i < NPIX; i++) begin
               cur_px.addr = i; cur_px.x = i % H; cur_px.y = i / H;
               cur_px.rgb = cur_pat ? cur_rgb : 24'(i) * 24'h010101;
               exp_q.push_back(cur_px);
            end
            live = 1'b1; rd_pending = 1'b0;
         end
         if (tmo_cnt != tmo_seen) begin tmo_seen = tmo_cnt; chk("frame_timeout", 32'd1, 32'd0); end
         chk("valid_while_busy", 32'(bif.drv_valid & bif.drv_busy), 32'd0);
         if (bif.mem_rd_en) begin
            chk("rd_expected", 32'(exp_q.size() != 0 && !cur_pat && !rd_pending), 32'd1);
            if (exp_q.size() != 0) chk("mem_addr", 32'(bif.mem_addr), 32'(exp_q[0].addr));
            rd_pending = 1'b1;
         end
         if (bif.drv_valid) begin
            if (exp_q.size() == 0) begin
               chk("extra_pixel", 32'd1, 32'd0);
            end else begin
               cur_px = exp_q.pop_front();
               chk("read_before_pixel", 32'(rd_pending), 32'(!cur_pat));
               chk("drv_rgb", 32'(bif.drv_rgb), 32'(cur_px.rgb));
               chk("pixel_x", 32'(pixel_x), 32'(cur_px.x));
               chk("pixel_y", 32'(pixel_y), 32'(cur_px.y));
               log_rgb.push_back(bif.drv_rgb); log_x.push_back(int'(pixel_x)); log_y.push_back(int'(pixel_y));
            end
            rd_pending = 1'b0;
         end
         if (frame_done) begin
            chk("done_expected", 32'(live && exp_q.size() == 0), 32'd1);
            live = 1'b0;
            model_fcnt = model_fcnt + 16'd1;
            done_cnt++;
            if (done_cnt == 1) begin
               chk("lit_npix", 32'(log_rgb.size()), 32'd8);
               if (log_rgb.size() == 8) begin
                  chk("lit_px2", 32'(log_rgb[2]), 32'h00020202);
                  chk("lit_px7", 32'(log_rgb[7]), 32'h00070707);
                  chk("lit_last_xy", 32'(log_x[7] * 16 + log_y[7]), 32'h31);
               end
               chk("lit_fcnt1", 32'(frame_count), 32'd1);
            end
            if (done_cnt == 2 && log_rgb.size() != 0) chk("lit_pattern_px", 32'(log_rgb[0]), 32'h00FF0000);
            if (model_fcnt == 16'd0) chk("lit_wrap", 32'(frame_count), 32'd0);
         end
         chk("frame_active", 32'(frame_active), 32'(live));
         chk("frame_count", 32'(frame_count), 32'(model_fcnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_frame(input bit pat, input logic [23:0] rgb);
      want_done = done_cnt + 1;
      pattern_en = pat; pattern_rgb = rgb;
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      cur_pat = pat; cur_rgb = rgb;
      frame_seq++;
   endtask

   task automatic wait_frame();
      int k = 0;
      while (done_cnt < want_done && k < 3000) begin
         pattern_en = 1'($urandom_range(1, 0));
         tick();
         k++;
      end
      if (done_cnt < want_done) begin tmo_cnt++; tick(); tick(); end
   endtask

   task automatic wait_pixels(input int n);
      int k = 0;
      while (!(frame_seen == frame_seq && log_rgb.size() >= n) && k < 1000) begin tick(); k++; end
      if (k >= 1000) begin tmo_cnt++; tick(); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern_en = 1'b0; pattern_rgb = 24'd0;
      busy_extra = 0; cur_pat = 1'b0; cur_rgb = 24'd0; pre_val = 16'd0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      begin_frame(1'b0, 24'd0);        wait_frame();
      begin_frame(1'b1, 24'hFF0000);   wait_frame();
      busy_extra = 10;
      begin_frame(1'b0, 24'd0);        wait_frame();
      busy_extra = 0;

      begin_frame(1'b0, 24'd0);
      wait_pixels(3);
      abort = 1'b1; tick(); abort = 1'b0;
      abort_seq++;
      repeat (40) tick();
      begin_frame(1'b0, 24'd0);        wait_frame();

      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      repeat (5) tick();
      abort = 1'b1; tick(); abort = 1'b0;
      repeat (3) tick();

      begin_frame(1'b1, 24'h00A5C3);
      repeat (7) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (9) tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_frame();

      for (int f = 0; f < 6; f++) begin
         busy_extra = int'($urandom_range(4, 0));
         begin_frame(1'($urandom_range(1, 0)), 24'($urandom));
         wait_frame();
         repeat ($urandom_range(5, 0)) tick();
      end
      busy_extra = 0;

      force dut.fcnt_q = 16'hFFFF;
      pre_val = 16'hFFFF; pre_seq++;
      tick();
      release dut.fcnt_q;
      tick();
      begin_frame(1'b0, 24'd0);        wait_frame();

      begin_frame(1'b0, 24'd0);
      wait_pixels(2);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tick();
      rst_n = 1'b1;
      tick();
      begin_frame(1'b1, 24'h123456);   wait_frame();
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
